// File: rtl/da2_multi.sv
// da2_multi -- multi-channel serial driver for PmodDA2-class DACs
// (DAC121S101 framing).
//
// On `update`, every channel's {2'b00, mode, value} frame is latched and
// shifted out MSB-first on its own SDATA line. All channels share one SCLK
// (generated from clk by a CLKDIV divider) and one SYNC strobe.
//
// Parameters:
//   NCH    channel count (>=1)
//   DW     DAC value width (1..12); frame width FW = DW+4
//   CLKDIV clk cycles per SCLK half-period (>=1)
//
// Ports:
//   clk     in   system clock, sole clock domain
//   rst_n   in   asynchronous active-low reset
//   update  in   frame request, level-sampled
//   chmode  in   [2*NCH-1:0]  per-channel power-down mode, ch i at [2i+1:2i]
//   value   in   [DW*NCH-1:0] per-channel DAC code, ch i at [DW*i+DW-1:DW*i]
//   SCLK    out  serial clock, idles high
//   SDATA   out  [NCH-1:0] serial data, bit i = channel i
//   SYNC    out  active-low frame strobe
//   working out  high from frame start until done
//   done    out  one-cycle pulse at end of frame plus gap
//
// Optional feature: define DA2_UPDATE_QUEUE_EN to remember one update that
// arrives while a frame is in progress and start it in the done cycle.

module da2_multi #(
  parameter int NCH    = 2,
  parameter int DW     = 12,
  parameter int CLKDIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              update,
  input  logic [2*NCH-1:0]  chmode,
  input  logic [DW*NCH-1:0] value,
  output logic              SCLK,
  output logic [NCH-1:0]    SDATA,
  output logic              SYNC,
  output logic              working,
  output logic              done
);

  localparam int FW   = DW + 4;
  localparam int CNTW = $clog2(FW + 1);
  localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DIVW-1:0] div;
  logic [CNTW-1:0] bitcnt;
  logic            sclk_q, sclk_nxt;
  logic            done_q, done_nxt;
  logic            tick;
  logic            req;
  logic            start;
  logic            shift_en;
  logic [FW-1:0]   sr [NCH];

  assign tick    = (div == DIV_LAST);
  assign working = (state != IDLE);
  assign SYNC    = (state != SHIFT);
  assign SCLK    = sclk_q;
  assign done    = done_q;

`ifdef DA2_UPDATE_QUEUE_EN
  // One-deep pending request; further updates during a frame merge into it.
  // It can only be consumed in the done cycle, the first IDLE cycle.
  logic pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pend <= 1'b0;
    else if (start)            pend <= 1'b0;
    else if (working && update) pend <= 1'b1;
  end

  assign req = update | pend;
`else
  assign req = update;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sclk_nxt  = sclk_q;
    done_nxt  = 1'b0;
    start     = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        sclk_nxt = 1'b1;
        if (req) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_nxt = ~sclk_q;
          // Rising SCLK edge: the DAC has sampled the current bit.
          if (!sclk_q) begin
            shift_en = 1'b1;
            if (bitcnt == CNT_LAST) state_nxt = GAP;
          end
        end
      end
      GAP: begin
        sclk_nxt = 1'b1;
        if (tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      bitcnt <= '0;
      sclk_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      sclk_q <= sclk_nxt;
      done_q <= done_nxt;
      // Divider restarts on every tick, which also aligns the GAP period.
      if (start || state == IDLE || tick) div <= '0;
      else                                 div <= div + 1'b1;
      if (start)         bitcnt <= '0;
      else if (shift_en) bitcnt <= bitcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) sr[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (start)         sr[i] <= {2'b00, chmode[2*i +: 2], value[DW*i +: DW]};
        else if (shift_en) sr[i] <= {sr[i][FW-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    SDATA = '0;
    for (int unsigned i = 0; i < NCH; i++) SDATA[i] = (state == SHIFT) & sr[i][FW-1];
  end

endmodule

// File: tb/tb_da2_multi.sv
// Bench for da2_multi: a cycle-level reference model pushes expected frames
// (start cycle plus per-channel frame word) into a queue when a request is
// accepted; an independent monitor decodes the serial pins and pops/compares
// at each done pulse. A second small instance covers the minimum parameters.

module tb_da2_multi;

  localparam int NCH    = 2;
  localparam int DW     = 12;
  localparam int CLKDIV = 2;
  localparam int FW     = DW + 4;
  localparam int PERIOD = (2 * FW + 1) * CLKDIV + 1;
  localparam int VW     = DW * NCH;
  localparam int CW     = 2 * NCH;
  localparam int E_FW   = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           update;
  logic [CW-1:0]  chmode;
  logic [VW-1:0]  value;
  logic           sclk, sync, working, done;
  logic [NCH-1:0] sdata;

  logic       e_update;
  logic [1:0] e_chmode;
  logic [7:0] e_value;
  logic       e_sclk, e_sync, e_working, e_done;
  logic [0:0] e_sdata;

  da2_multi #(.NCH(NCH), .DW(DW), .CLKDIV(CLKDIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .update(update), .chmode(chmode), .value(value),
    .SCLK(sclk), .SDATA(sdata), .SYNC(sync), .working(working), .done(done)
  );

  da2_multi #(.NCH(1), .DW(8), .CLKDIV(1)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .update(e_update), .chmode(e_chmode), .value(e_value),
    .SCLK(e_sclk), .SDATA(e_sdata), .SYNC(e_sync), .working(e_working), .done(e_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                    start;
    logic [NCH*FW-1:0]     frames;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   free_at = 0;
  bit   pend    = 1'b0;

  always @(posedge clk) begin : model
    exp_t e;
    cyc++;
    if (!rst_n) begin
      free_at = 0;
      pend    = 1'b0;
      exp_q.delete();
    end else if (cyc >= free_at) begin
      if (update || pend) begin
        e.start  = cyc;
        e.frames = '0;
        for (int c = 0; c < NCH; c++)
          e.frames[c*FW +: FW] = FW'((int'(chmode[2*c +: 2]) << DW) | int'(value[DW*c +: DW]));
        exp_q.push_back(e);
        free_at = cyc + PERIOD;
        pend    = 1'b0;
      end
    end
`ifdef DA2_UPDATE_QUEUE_EN
    else if (update) pend = 1'b1;
`endif
  end

  // ---------------- monitor ----------------
  int          m_phase = 0;  // 0 idle, 1 sync low, 2 gap
  int          m_start, m_low, m_nbits, m_gap;
  logic [FW-1:0] m_bits    [NCH];
  logic [FW-1:0] last_bits [NCH];
  logic        m_prev_sclk = 1'b1;
  int          n_frames = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      m_phase     = 0;
      m_prev_sclk = 1'b1;
      check("reset_idle", {sclk, sync, sdata, working, done},
            {1'b1, 1'b1, {NCH{1'b0}}, 1'b0, 1'b0});
    end else begin
      if (m_phase == 0) begin
        if (done) check("spurious_done", done, 1'b0);
        if (!sync) begin
          m_phase = 1;
          m_start = cyc;
          m_low   = 0;
          m_nbits = 0;
          for (int c = 0; c < NCH; c++) m_bits[c] = '0;
          check("working_at_start", working, 1'b1);
        end
      end
      if (m_phase == 1) begin
        if (done) check("done_in_frame", done, 1'b0);
        if (!sync) begin
          m_low++;
          if (m_prev_sclk && !sclk) begin
            for (int c = 0; c < NCH; c++) m_bits[c] = {m_bits[c][FW-2:0], sdata[c]};
            m_nbits++;
          end
        end else begin
          m_phase = 2;
          m_gap   = 0;
        end
      end
      if (m_phase == 2) begin
        if (done) begin
          check("working_at_done", working, 1'b0);
          check("gap_cycles", m_gap, CLKDIV);
          if (exp_q.size() == 0) begin
            check("frame_expected", 1'b0, 1'b1);
          end else begin
            e = exp_q.pop_front();
            check("start_cycle", m_start, e.start);
            check("sync_low_cycles", m_low, 2 * FW * CLKDIV);
            check("bit_count", m_nbits, FW);
            for (int c = 0; c < NCH; c++)
              check($sformatf("ch%0d_frame", c), m_bits[c], e.frames[c*FW +: FW]);
            check("done_cycle", cyc, e.start + PERIOD - 1);
          end
          for (int c = 0; c < NCH; c++) last_bits[c] = m_bits[c];
          n_frames++;
          m_phase = 0;
        end else begin
          m_gap++;
          if (m_gap > CLKDIV + 1) begin
            check("done_timeout", 1'b0, 1'b1);
            m_phase = 0;
          end
        end
      end
      m_prev_sclk = sclk;
    end
  end

  // Minimal-parameter instance: plain pin decoder.
  int              e_low = 0, e_nb = 0, e_ndone = 0;
  logic [E_FW-1:0] e_bits = '0;
  logic            e_prev_sclk = 1'b1;

  always @(negedge clk) begin : monitor_min
    if (!rst_n) begin
      e_low = 0; e_nb = 0; e_ndone = 0; e_bits = '0; e_prev_sclk = 1'b1;
    end else begin
      if (!e_sync) begin
        e_low++;
        if (e_prev_sclk && !e_sclk) begin
          e_bits = {e_bits[E_FW-2:0], e_sdata[0]};
          e_nb++;
        end
      end
      if (e_done) e_ndone++;
      e_prev_sclk = e_sclk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_inputs();
    chmode = CW'($urandom());
    value  = VW'($urandom());
  endtask

  task automatic run_rand(input int n);
    repeat (n) begin
      @(negedge clk);
      rand_inputs();
    end
  endtask

  task automatic pulse();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    rand_inputs();
  endtask

  int f0;

  initial begin
    rst_n = 1'b1; update = 1'b0; chmode = '0; value = '0;
    e_update = 1'b0; e_chmode = '0; e_value = '0;
    #2 rst_n = 1'b0;

    // Reset held while update toggles.
    repeat (10) begin
      @(negedge clk);
      update   = 1'($urandom());
      e_update = 1'($urandom());
      rand_inputs();
    end
    @(negedge clk);
    update = 1'b0; e_update = 1'b0; rst_n = 1'b1;
    run_rand(2);

    // Minimum parameters: 12-bit frame, SCLK at clk/2.
    e_chmode = 2'd1; e_value = 8'hFF; e_update = 1'b1;
    @(negedge clk);
    e_update = 1'b0; e_chmode = 2'd2; e_value = 8'h00;
    run_rand(40);
    check("min_frame", e_bits, 12'h1FF);
    check("min_bits", e_nb, 12);
    check("min_sync_low", e_low, 24);
    check("min_done_count", e_ndone, 1);

    // Single directed frame.
    chmode = {2'd3, 2'd0};
    value  = {12'h005, 12'hABC};
    f0 = n_frames;
    pulse();
    run_rand(80);
    check("single_count", n_frames - f0, 1);
    check("single_ch0", last_bits[0], 16'h0ABC);
    check("single_ch1", last_bits[1], 16'h3005);

    // Back-to-back: update held for 300 cycles -> starts at 0,67,134,201,268.
    f0 = n_frames;
    update = 1'b1;
    run_rand(300);
    update = 1'b0;
    run_rand(80);
    check("b2b_count", n_frames - f0, 5);

    // Second update 20 cycles into a frame.
    f0 = n_frames;
    rand_inputs();
    pulse();
    run_rand(20);
    pulse();
    run_rand(150);
`ifdef DA2_UPDATE_QUEUE_EN
    check("midframe_update_count", n_frames - f0, 2);
`else
    check("midframe_update_count", n_frames - f0, 1);
`endif

    // Reset asserted around bit 7, then a clean frame.
    f0 = n_frames;
    pulse();
    run_rand(29);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sclk", sclk, 1'b1);
    check("abort_sync", sync, 1'b1);
    check("abort_sdata", sdata, '0);
    run_rand(5);
    rst_n = 1'b1;
    run_rand(2);
    pulse();
    run_rand(80);
    check("after_reset_count", n_frames - f0, 1);

    // Random update patterns.
    repeat (15) begin
      update = 1'b1;
      run_rand($urandom_range(1, 3));
      update = 1'b0;
      run_rand($urandom_range(0, 90));
    end

    update = 1'b0;
    run_rand(150);
    check("queue_drained", exp_q.size(), 0);
    check("monitor_idle", m_phase, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
